// File: rtl/slowfast_pkg.sv
// Package: slowfast_pkg
// Shared constants and helpers for the slowfast capture path.
//   edge_mode_t  - capture-edge selection (rising, falling or both)
//   ev_select    - picks the capture event from the rise/fall detector outputs
package slowfast_pkg;

  typedef enum int {
    EDGE_RISE = 0,
    EDGE_FALL = 1,
    EDGE_BOTH = 2
  } edge_mode_t;

  // Select the capture event for a given edge mode. Unknown modes are
  // rejected at elaboration, so the default arm only has to cover EDGE_RISE.
  function automatic logic ev_select(input int mode, input logic rise, input logic fall);
    case (mode)
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Module: sync_edge_det
// Brings an asynchronous strobe into the Aclk domain through a STAGES-deep
// flop chain and flags the selected edge of the synchronised level.
// Ports:
//   Aclk        in  clock, rising edge
//   reset       in  asynchronous active-high reset, clears every flop
//   strb_async  in  strobe from the slow domain
//   ev          out one-cycle event on the selected edge of the synchronised strobe
module sync_edge_det
  import slowfast_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic Aclk,
  input  logic reset,
  input  logic strb_async,
  output logic ev
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_edge_det: STAGES must be >= 2");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("sync_edge_det: EDGE_MODE must be 0, 1 or 2");
  end

  logic [STAGES-1:0] sync_chain;
  logic              sync;
  logic              sync_q;
  logic              rise;
  logic              fall;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its neighbour held before this edge.
  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
      sync_q     <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[STAGES-2:0], strb_async};
      sync_q     <= sync_chain[STAGES-1];
    end
  end

  assign sync = sync_chain[STAGES-1];

  // NOTE: each combinational output is given a value before any condition,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rise = 1'b0;
    fall = 1'b0;
    ev   = 1'b0;
    rise = sync & ~sync_q;
    fall = ~sync & sync_q;
    ev   = ev_select(EDGE_MODE, rise, fall);
  end

endmodule

// File: rtl/slowfast_capture.sv
// Module: slowfast_capture
// Single-domain capture path: builds a serial word, snapshots it when a
// synchronised strobe edge arrives and offers the snapshot on valid/ready.
// Ports:
//   Aclk        in  sole clock, rising edge
//   reset       in  asynchronous active-high reset, clears every flop
//   ser_sel     in  0: internal toggle pattern, 1: ser_in feeds the shift register
//   ser_in      in  external serial bit (Aclk-synchronous)
//   strb_async  in  asynchronous capture strobe
//   out_data    out captured word (holds its last value once consumed)
//   out_valid   out out_data holds an unconsumed capture
//   out_ready   in  consumer accepts out_data when out_valid && out_ready
//   overrun     out sticky flag: a capture arrived while the slot was full
//   clr_ovr     in  clears overrun and drop_cnt (a simultaneous drop wins)
//   cap_cnt     out accepted captures, wraps
//   drop_cnt    out dropped captures, saturates at all-ones
module slowfast_capture
  import slowfast_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int CNT_W       = 8
) (
  input  logic             Aclk,
  input  logic             reset,
  input  logic             ser_sel,
  input  logic             ser_in,
  input  logic             strb_async,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] cap_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  if (WIDTH < 2) begin : g_bad_width
    $error("slowfast_capture: WIDTH must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("slowfast_capture: SYNC_STAGES must be >= 2");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("slowfast_capture: EDGE_MODE must be 0, 1 or 2");
  end

  logic             pat;
  logic             serial_bit;
  logic [WIDTH-1:0] sh;
  logic             ev;
  logic             free;
  logic             accept;
  logic             drop;

  sync_edge_det #(
    .STAGES   (SYNC_STAGES),
    .EDGE_MODE(EDGE_MODE)
  ) u_sync_edge_det (
    .Aclk      (Aclk),
    .reset     (reset),
    .strb_async(strb_async),
    .ev        (ev)
  );

  // Serial word: newest bit enters at sh[0] every cycle.
  assign serial_bit = ser_sel ? ser_in : pat;

  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      pat <= 1'b0;
      sh  <= '0;
    end else begin
      pat <= ~pat;
      sh  <= {sh[WIDTH-2:0], serial_bit};
    end
  end

  // The slot can take a new word if it is empty or being emptied this cycle.
  assign free   = ~out_valid | out_ready;
  assign accept = ev & free;
  assign drop   = ev & ~free;

  // NOTE: out_data is reset along with the control flops; it is a single
  // register, not a memory, and downstream logic may look at it while idle.
  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      cap_cnt   <= '0;
    end else if (accept) begin
      out_data  <= sh;
      out_valid <= 1'b1;
      cap_cnt   <= cap_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_ovr leaves the flag set and the count
  // at one, so the event that coincided with the clear is never lost.
  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clr_ovr) begin
        drop_cnt <= CNT_W'(1);
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end else if (clr_ovr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_slowfast_capture.sv
// Testbench: tb_slowfast_capture
// Three instances share one stimulus: defaults (inst0), EDGE_MODE=both (inst1)
// and CNT_W=2 (inst2). A history-based reference model predicts every output.
module tb_slowfast_capture;
  import slowfast_pkg::*;

  localparam int SS = 2;  // synchroniser depth used by every instance

  logic Aclk = 1'b0;
  logic reset = 1'b1;
  logic ser_sel = 1'b0, ser_in = 1'b0, strb_async = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;

  logic [3:0] d0_data, db_data, ds_data;
  logic       d0_valid, db_valid, ds_valid;
  logic       d0_ovr, db_ovr, ds_ovr;
  logic [7:0] d0_cap, d0_drop, db_cap, db_drop;
  logic [1:0] ds_cap, ds_drop;

  always #5 Aclk = ~Aclk;

  slowfast_capture u_dut (
    .Aclk(Aclk), .reset(reset), .ser_sel(ser_sel), .ser_in(ser_in), .strb_async(strb_async),
    .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready), .overrun(d0_ovr),
    .clr_ovr(clr_ovr), .cap_cnt(d0_cap), .drop_cnt(d0_drop));

  slowfast_capture #(.EDGE_MODE(EDGE_BOTH)) u_both (
    .Aclk(Aclk), .reset(reset), .ser_sel(ser_sel), .ser_in(ser_in), .strb_async(strb_async),
    .out_data(db_data), .out_valid(db_valid), .out_ready(out_ready), .overrun(db_ovr),
    .clr_ovr(clr_ovr), .cap_cnt(db_cap), .drop_cnt(db_drop));

  slowfast_capture #(.CNT_W(2)) u_small (
    .Aclk(Aclk), .reset(reset), .ser_sel(ser_sel), .ser_in(ser_in), .strb_async(strb_async),
    .out_data(ds_data), .out_valid(ds_valid), .out_ready(out_ready), .overrun(ds_ovr),
    .clr_ovr(clr_ovr), .cap_cnt(ds_cap), .drop_cnt(ds_drop));

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // History of sampled inputs since reset; index 0 = sample at the previous edge.
  bit ser_h[8];
  bit st_h[8];
  int ed;
  int m_data[3], m_valid[3], m_ovr[3], m_cap[3], m_drop[3];

  function automatic int mode_of(int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int cmax_of(int i);
    return (i == 2) ? 3 : 255;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < 8; j++) begin
      ser_h[j] = 1'b0;
      st_h[j]  = 1'b0;
    end
    ed = 0;
    for (int i = 0; i < 3; i++) begin
      m_data[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_cap[i] = 0; m_drop[i] = 0;
    end
  endfunction

  // One clock edge: an input change sampled SS edges ago shows up as an
  // event now, and the word seen is the last four serial bits before this edge.
  function automatic void model_edge();
    bit rise, fall, ev, free, b;
    int word;
    rise = st_h[SS-1] && !st_h[SS];
    fall = !st_h[SS-1] && st_h[SS];
    word = 0;
    for (int j = 0; j < 4; j++) word += int'(ser_h[j]) << j;
    for (int i = 0; i < 3; i++) begin
      ev   = (mode_of(i) == 0) ? rise : (rise || fall);
      free = (m_valid[i] == 0) || out_ready;
      if (ev && free) begin
        m_data[i] = word; m_valid[i] = 1; m_cap[i] = (m_cap[i] + 1) % (cmax_of(i) + 1);
      end else if (!ev && m_valid[i] != 0 && out_ready) begin
        m_valid[i] = 0;
      end
      if (ev && !free) begin
        m_ovr[i]  = 1;
        m_drop[i] = clr_ovr ? 1 : ((m_drop[i] == cmax_of(i)) ? m_drop[i] : m_drop[i] + 1);
      end else if (clr_ovr) begin
        m_ovr[i] = 0; m_drop[i] = 0;
      end
    end
    b = ser_sel ? ser_in : ed[0];  // toggle pattern is 0 before the first edge after reset
    ed++;
    for (int j = 7; j > 0; j--) begin
      ser_h[j] = ser_h[j-1];
      st_h[j]  = st_h[j-1];
    end
    ser_h[0] = b;
    st_h[0]  = strb_async;
  endfunction

  function automatic logic [21:0] obs(int i);
    case (i)
      0:       return {d0_data, d0_valid, d0_ovr, d0_cap, d0_drop};
      1:       return {db_data, db_valid, db_ovr, db_cap, db_drop};
      default: return {ds_data, ds_valid, ds_ovr, 6'd0, ds_cap, 6'd0, ds_drop};
    endcase
  endfunction

  function automatic logic [21:0] expv(int i);
    return {4'(m_data[i]), 1'(m_valid[i]), 1'(m_ovr[i]), 8'(m_cap[i]), 8'(m_drop[i])};
  endfunction

  // Advance one clock: the model sees the inputs driven at the previous
  // negedge; outputs are then read at the following negedge.
  task automatic cycle();
    @(posedge Aclk);
    if (!reset) model_edge();
    @(negedge Aclk);
  endtask

  task automatic apply_reset(int n);
    reset = 1'b1;
    model_reset();
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic pulse(int hi, int lo);
    strb_async = 1'b1;
    repeat (hi) cycle();
    strb_async = 1'b0;
    repeat (lo) cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ser_sel = 0; out_ready = 0; strb_async = 0; ser_in = 0; clr_ovr = 0;
    apply_reset(2);
    for (int c = 0; c < 5; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== 22'd0 || obs(i) !== expv(i))
          $display("FAIL reset_idle inst%0d cyc%0d: got %h want 0", i, c, obs(i));
        else n_pass++;
      end
    end
    // sh runs 0,1,2,5,A,5,A: a strobe sampled at edge 6 captures the value after edge 7
    strb_async = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (d0_valid !== 1'b1 || d0_data !== 4'hA)
      $display("FAIL pattern_word: got valid=%b data=%h want valid=1 data=a", d0_valid, d0_data);
    else n_pass++;
  endtask

  task automatic test_capture_latency();
    logic [2:0] seen;
    strb_async = 0;
    apply_reset(1);
    ser_sel = 1; ser_in = 1;
    repeat (6) cycle();
    strb_async = 1'b1;
    for (int e = 0; e < 3; e++) begin
      cycle();
      seen[e] = d0_valid;
    end
    n_checks++;
    if (seen !== 3'b100) $display("FAIL latency: valid after edges k..k+2 got %b want 100", seen);
    else n_pass++;
    n_checks++;
    if (obs(0) !== {4'hF, 1'b1, 1'b0, 8'd1, 8'd0})
      $display("FAIL first_capture: got %h want %h", obs(0), {4'hF, 1'b1, 1'b0, 8'd1, 8'd0});
    else n_pass++;
  endtask

  task automatic test_overrun();
    ser_in = 0;  // new serial bits differ, so an overwrite would be visible
    pulse(0, 4);
    pulse(4, 0);
    repeat (2) cycle();
    n_checks++;
    if (obs(0) !== {4'hF, 1'b1, 1'b1, 8'd1, 8'd1})
      $display("FAIL overrun_set: got %h want %h", obs(0), {4'hF, 1'b1, 1'b1, 8'd1, 8'd1});
    else n_pass++;
    clr_ovr = 1; cycle(); clr_ovr = 0;
    n_checks++;
    if (d0_ovr !== 1'b0 || d0_drop !== 8'd0)
      $display("FAIL overrun_clear: got ovr=%b drop=%0d want 0/0", d0_ovr, d0_drop);
    else n_pass++;
    // two more drops, the second coinciding with clr_ovr
    pulse(0, 4);
    pulse(4, 4);
    strb_async = 1'b1;
    cycle(); cycle();
    clr_ovr = 1; cycle(); clr_ovr = 0;
    n_checks++;
    if (d0_ovr !== 1'b1 || d0_drop !== 8'd1 || d0_cap !== 8'd1)
      $display("FAIL set_wins: got ovr=%b drop=%0d cap=%0d want 1/1/1", d0_ovr, d0_drop, d0_cap);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs(i) !== expv(i)) $display("FAIL overrun_model inst%0d: got %h want %h", i, obs(i), expv(i));
      else n_pass++;
    end
    strb_async = 0;
    repeat (4) cycle();
  endtask

  task automatic test_back_to_back();
    int cnt0, cntb;
    cnt0 = 0; cntb = 0;
    apply_reset(1);
    ser_sel = 0; out_ready = 1;
    for (int p = 0; p < 3; p++) begin
      strb_async = 1'b1;
      repeat (4) begin cycle(); cnt0 += int'(d0_valid); cntb += int'(db_valid); end
      strb_async = 1'b0;
      repeat (4) begin cycle(); cnt0 += int'(d0_valid); cntb += int'(db_valid); end
    end
    repeat (4) begin cycle(); cnt0 += int'(d0_valid); cntb += int'(db_valid); end
    n_checks++;
    if (cnt0 !== 3 || d0_cap !== 8'd3 || d0_ovr !== 1'b0)
      $display("FAIL pulses_rise: got valid_cycles=%0d cap=%0d ovr=%b want 3/3/0", cnt0, d0_cap, d0_ovr);
    else n_pass++;
    n_checks++;
    if (cntb !== 6 || db_cap !== 8'd6 || db_ovr !== 1'b0)
      $display("FAIL pulses_both: got valid_cycles=%0d cap=%0d ovr=%b want 6/6/0", cntb, db_cap, db_ovr);
    else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    strb_async = 1'b1;
    cycle();
    reset = 1'b1;
    model_reset();
    cycle();
    strb_async = 1'b0;
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== 22'd0) $display("FAIL reset_in_flight inst%0d cyc%0d: got %h want 0", i, c, obs(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturate_wrap();
    logic [1:0] want_cap;
    apply_reset(1);
    out_ready = 0;
    repeat (6) pulse(4, 4);
    n_checks++;
    if (ds_ovr !== 1'b1 || ds_drop !== 2'd3 || ds_cap !== 2'd1)
      $display("FAIL drop_saturate: got ovr=%b drop=%0d cap=%0d want 1/3/1", ds_ovr, ds_drop, ds_cap);
    else n_pass++;
    n_checks++;
    if (d0_drop !== 8'd5) $display("FAIL drop_count: got %0d want 5", d0_drop);
    else n_pass++;
    out_ready = 1;
    for (int p = 0; p < 3; p++) begin
      pulse(4, 4);
      want_cap = 2'(p + 2);
      n_checks++;
      if (ds_cap !== want_cap) $display("FAIL cap_wrap pulse%0d: got %0d want %0d", p, ds_cap, want_cap);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs(i) !== expv(i)) $display("FAIL wrap_model inst%0d: got %h want %h", i, obs(i), expv(i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int hold;
    strb_async = 0;
    apply_reset(1);
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        strb_async = ~strb_async;
        hold = int'($urandom_range(1, 5));
      end
      hold--;
      ser_sel   = 1'($urandom);
      ser_in    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_ovr   = ($urandom_range(0, 9) == 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs(i) !== expv(i)) $display("FAIL random inst%0d cyc%0d: got %h want %h", i, c, obs(i), expv(i));
        else n_pass++;
      end
    end
    clr_ovr = 0;
  endtask

  initial begin
    model_reset();
    @(negedge Aclk);
    test_reset();
    test_capture_latency();
    test_overrun();
    test_back_to_back();
    test_reset_in_flight();
    test_saturate_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
